// File: rtl/array_24_pkg.sv
// Shared geometry and state encoding for the array_24 request front-end.
package array_24_pkg;

    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned DATA_W      = 96;
    localparam int unsigned MASK_W      = 16;
    localparam int unsigned GRAN_W      = 6;
    localparam int unsigned NUM_ENTRIES = 4096;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

endpackage

// File: rtl/array_24_resp_fifo.sv
// Response FIFO: RESP_DEPTH x DATA_W, pointers wrap modulo RESP_DEPTH, exposes occupancy.
module array_24_resp_fifo
    import array_24_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 2,
    localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1),
    localparam int unsigned PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates everything visible downstream.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/array_24_req_ctrl.sv
// Request front-end for array_24_ext: post-reset zero-fill, then valid/ready to RW0 cycles
// with credit-based read admission into a response FIFO.
module array_24_req_ctrl
    import array_24_pkg::*;
#(
    parameter bit          INIT_EN    = 1'b1,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic              init_arm_q;
    logic              rd_pending_q, rd_pending_d;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W:0]    demand;
    logic              pop;
    logic              admit;

    assign resp_valid = (occ != '0);
    assign pop        = resp_valid & resp_ready;
    // Slots already claimed once this cycle's pop is taken into account.
    assign demand     = {1'b0, occ} + (CNT_W + 1)'(rd_pending_q) - (CNT_W + 1)'(pop);
    assign admit      = demand < (CNT_W + 1)'(RESP_DEPTH);
    assign init_done  = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        req_ready   = 1'b0;
        RW0_en      = 1'b0;
        RW0_wmode   = 1'b0;
        RW0_addr    = init_addr_q;
        RW0_wmask   = '0;
        RW0_wdata   = '0;
        unique case (state_q)
            INIT: begin
                // init_arm_q holds off the first write until the first edge after release.
                RW0_en    = init_arm_q;
                RW0_wmode = 1'b1;
                RW0_wmask = '1;
                if (init_arm_q) begin
                    init_addr_d = init_addr_q + 1'b1;
                    if (init_addr_q == ADDR_W'(NUM_ENTRIES - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                req_ready = req_write | admit;
                RW0_en    = req_valid & req_ready;
                RW0_wmode = req_write;
                RW0_addr  = req_addr;
                RW0_wmask = req_wmask;
                RW0_wdata = req_wdata;
            end
        endcase
    end

    assign rd_pending_d = RW0_en & ~RW0_wmode;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT_EN ? INIT : RUN;
            init_addr_q  <= '0;
            init_arm_q   <= 1'b0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            init_arm_q   <= 1'b1;
            rd_pending_q <= rd_pending_d;
        end
    end

    array_24_resp_fifo #(
        .RESP_DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (rd_pending_q),
        .push_data_i (RW0_rdata),
        .pop_i       (pop),
        .data_o      (resp_data),
        .count_o     (occ)
    );

endmodule

// File: tb/tb_array_24_req_ctrl.sv
// Directed bench for array_24_req_ctrl with a behavioural model of the array_24_ext macro.
module tb_array_24_req_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [15:0] req_wmask;
    logic [95:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [95:0] resp_data;
    logic        init_done;
    logic [11:0] RW0_addr;
    logic        RW0_en;
    logic        RW0_wmode;
    logic [15:0] RW0_wmask;
    logic [95:0] RW0_wdata;
    logic [95:0] RW0_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    array_24_req_ctrl #(
        .INIT_EN    (1'b1),
        .RESP_DEPTH (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata)
    );

    // Macro model: masked write, one-cycle registered read, old data on same-edge collision.
    logic [95:0] mem [4096];
    logic [95:0] rdata_q;
    logic [95:0] wtmp;
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                wtmp = mem[RW0_addr];
                for (int g = 0; g < 16; g++) begin
                    if (RW0_wmask[g]) wtmp[g*6 +: 6] = RW0_wdata[g*6 +: 6];
                end
                mem[RW0_addr] <= wtmp;
            end else begin
                rdata_q <= mem[RW0_addr];
            end
        end
    end
    assign RW0_rdata = rdata_q;

    logic track_init = 1'b0;
    int   hits [4096];
    int   bad_word = 0;
    always @(posedge clock) begin
        if (track_init && RW0_en && !init_done) begin
            hits[RW0_addr] <= hits[RW0_addr] + 1;
            if (!RW0_wmode || RW0_wmask != 16'hFFFF || RW0_wdata != '0) bad_word <= bad_word + 1;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic w, input logic [11:0] a, input logic [15:0] m,
                       input logic [95:0] d, output logic acc);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        #4;
        acc = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic exp_resp(input string tag, input logic [95:0] d);
        #4;
        check({tag, "_valid"}, 96'(resp_valid), 96'd1);
        check(tag, resp_data, d);
        tick();
    endtask

    function automatic logic [95:0] pat(input int i);
        logic [11:0] t;
        t = 12'h5A0 + i[11:0];
        return {8{t}};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   done_cycle;
        int   order_err;
        int   miss;
        done_cycle = -1;
        order_err  = 0;
        miss       = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wmask  = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            mem[a]  = '1;
            hits[a] = 0;
        end
        track_init = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 96'(req_ready), 96'd0);
        check("rst_resp_valid", 96'(resp_valid), 96'd0);
        check("rst_init_done", 96'(init_done), 96'd0);
        check("rst_rw0_en", 96'(RW0_en), 96'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("pre_edge0_en", 96'(RW0_en), 96'd0);

        // Cycle c is the interval after edge c counted from the first edge after release.
        tick();
        for (int c = 0; c < 4200; c++) begin
            #4;
            if (init_done) begin
                done_cycle = c;
                break;
            end
            if (req_ready || !RW0_en || RW0_addr != c[11:0]) order_err++;
            tick();
        end
        if (done_cycle >= 0) tick();
        track_init = 1'b0;
        check("init_done_cycle", 96'(done_cycle), 96'd4096);
        check("init_order", 96'(order_err), 96'd0);
        for (int a = 0; a < 4096; a++) if (hits[a] != 1) miss++;
        check("init_once_each", 96'(miss), 96'd0);
        check("init_word", 96'(bad_word), 96'd0);

        req(1'b0, 12'hFFF, 16'h0, 96'h0, acc);
        check("rd_fff_acc", 96'(acc), 96'd1);
        tick();
        exp_resp("rd_fff", 96'h0);

        req(1'b1, 12'h3A5, 16'hFFFF, 96'h0123_4567_89AB_CDEF_0011_2233, acc);
        check("wr_3a5_acc", 96'(acc), 96'd1);
        req(1'b0, 12'h3A5, 16'h0, 96'h0, acc);
        tick();
        exp_resp("raw_3a5", 96'h0123_4567_89AB_CDEF_0011_2233);

        req(1'b1, 12'h010, 16'hFFFF, '1, acc);
        req(1'b1, 12'h010, 16'h0001, 96'h0, acc);
        req(1'b0, 12'h010, 16'h0, 96'h0, acc);
        tick();
        exp_resp("mask_010", 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFC0);

        for (int i = 0; i < 8; i++) req(1'b1, i[11:0], 16'hFFFF, pat(i), acc);
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = i[11:0];
            end else begin
                req_valid = 1'b0;
            end
            #4;
            if (i < 8) check("b2b_ready", 96'(req_ready), 96'd1);
            if (i >= 2 && i < 10) begin
                check("b2b_valid", 96'(resp_valid), 96'd1);
                check("b2b_data", resp_data, pat(i - 2));
            end
            if (i == 10) check("b2b_drained", 96'(resp_valid), 96'd0);
            tick();
        end
        req_valid = 1'b0;

        resp_ready = 1'b0;
        req(1'b0, 12'd0, 16'h0, 96'h0, acc);
        check("bp_rd0_acc", 96'(acc), 96'd1);
        req(1'b0, 12'd1, 16'h0, 96'h0, acc);
        check("bp_rd1_acc", 96'(acc), 96'd1);
        req(1'b0, 12'd2, 16'h0, 96'h0, acc);
        check("bp_rd2_stall", 96'(acc), 96'd0);
        req(1'b0, 12'd3, 16'h0, 96'h0, acc);
        check("bp_rd3_stall", 96'(acc), 96'd0);
        req(1'b1, 12'h020, 16'hFFFF, 96'h5, acc);
        check("bp_wr_acc", 96'(acc), 96'd1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 12'd5;
        #4;
        check("bp_rd5_acc", 96'(req_ready), 96'd1);
        check("bp_head0", resp_data, pat(0));
        tick();
        req_valid = 1'b0;
        exp_resp("bp_head1", pat(1));
        exp_resp("bp_rd5", pat(5));
        #4;
        check("bp_empty", 96'(resp_valid), 96'd0);
        tick();

        resp_ready = 1'b0;
        req(1'b0, 12'd6, 16'h0, 96'h0, acc);
        req(1'b0, 12'd7, 16'h0, 96'h0, acc);
        tick();
        #1;
        check("rst_buffered", 96'(resp_valid), 96'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 96'(resp_valid), 96'd0);
        check("rst_async_done", 96'(init_done), 96'd0);
        check("rst_async_en", 96'(RW0_en), 96'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        #4;
        check("reinit_addr0", 96'(RW0_addr), 96'd0);
        check("reinit_en", 96'(RW0_en), 96'd1);
        check("reinit_ready", 96'(req_ready), 96'd0);
        tick();
        #4;
        check("reinit_addr1", 96'(RW0_addr), 96'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
